// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command controller: default opcodes, read
// timeout and timer width, and the FSM state encodings.
package uart_cmd_pkg;

   localparam logic [7:0] CMD_WR_DEF     = 8'hAA;
   localparam logic [7:0] CMD_RD_DEF     = 8'hBB;
   localparam int         RD_TIMEOUT_DEF = 15;

   // The count can land on the timeout value itself on the expiry edge.
   function automatic int tmr_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

   localparam int TMR_W = tmr_width(RD_TIMEOUT_DEF);

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_WR_ADDR = 3'd1;
   localparam state_t ST_WR_DATA = 3'd2;
   localparam state_t ST_RD_ADDR = 3'd3;
   localparam state_t ST_RD_WAIT = 3'd4;
   localparam state_t ST_TX_SEND = 3'd5;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bundle of UART receive, register-file and UART transmit signals around the
// command controller; master is the controller, slave is its environment.
interface uart_cmd_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] RX_P_DATA;
   logic                  RX_D_VLD;
   logic                  RX_PAR_ERR;
   logic                  RX_STP_ERR;

   logic                  RF_WrEn;
   logic                  RF_RdEn;
   logic [ADDR_WIDTH-1:0] RF_Address;
   logic [DATA_WIDTH-1:0] RF_WrData;
   logic [DATA_WIDTH-1:0] RF_RdData;
   logic                  RF_RdData_VLD;

   logic [DATA_WIDTH-1:0] TX_P_DATA;
   logic                  TX_D_VLD;
   logic                  TX_BUSY;
   logic                  CMD_ERR;

   modport master (
      input  RX_P_DATA, RX_D_VLD, RX_PAR_ERR, RX_STP_ERR,
      input  RF_RdData, RF_RdData_VLD, TX_BUSY,
      output RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
      output TX_P_DATA, TX_D_VLD, CMD_ERR
   );

   modport slave (
      output RX_P_DATA, RX_D_VLD, RX_PAR_ERR, RX_STP_ERR,
      output RF_RdData, RF_RdData_VLD, TX_BUSY,
      input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
      input  TX_P_DATA, TX_D_VLD, CMD_ERR
   );

endinterface

// File: rtl/uart_cmd_ctrl_timer.sv
// Read-wait timeout counter: synchronous clear, count enable, and a terminal
// count that flags the last waiting cycle before the timeout expires.
module uart_cmd_timer
   import uart_cmd_pkg::*;
#(
   parameter int WIDTH    = TMR_W,
   parameter int TERMINAL = RD_TIMEOUT_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_tc = (r_count == WIDTH'(TERMINAL - 1));

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses AA/BB write/read frames into register-file
// strobes and returns read data to the UART transmitter.
// Define UART_CMD_ERR_ABORT_EN to abort a frame on any byte with a parity/stop error.
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 4,
   parameter logic [DATA_WIDTH-1:0] CMD_WR     = CMD_WR_DEF,
   parameter logic [DATA_WIDTH-1:0] CMD_RD     = CMD_RD_DEF,
   parameter int                    RD_TIMEOUT = RD_TIMEOUT_DEF
) (
   input  logic            CLK,
   input  logic            RST,
   uart_cmd_ctrl_if.master bus
);

   localparam int TW = tmr_width(RD_TIMEOUT);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic                  r_rf_wren;
   logic                  r_rf_rden;
   logic [ADDR_WIDTH-1:0] r_rf_addr;
   logic [DATA_WIDTH-1:0] r_rf_wrdata;
   logic [DATA_WIDTH-1:0] r_tx_p_data;
   logic                  r_tx_d_vld;
   logic                  r_cmd_err;

   logic w_byte_err;
   logic w_parsing;
   logic w_abort;
   logic w_tmr_clr;
   logic w_tmr_en;
   logic w_tmr_tc;

`ifdef UART_CMD_ERR_ABORT_EN
   assign w_byte_err = bus.RX_PAR_ERR | bus.RX_STP_ERR;
`else
   logic w_unused_err;
   assign w_unused_err = bus.RX_PAR_ERR | bus.RX_STP_ERR;
   assign w_byte_err   = 1'b0;
`endif

   // Only frame-building states may be aborted; RD_WAIT/TX_SEND drop bytes anyway.
   assign w_parsing = (r_state == ST_IDLE)    || (r_state == ST_WR_ADDR) ||
                      (r_state == ST_WR_DATA) || (r_state == ST_RD_ADDR);
   assign w_abort   = bus.RX_D_VLD && w_byte_err && w_parsing;
   assign w_tmr_clr = (r_state == ST_RD_ADDR) && bus.RX_D_VLD && !w_byte_err;
   assign w_tmr_en  = (r_state == ST_RD_WAIT);

   uart_cmd_timer #(
      .WIDTH    (TW),
      .TERMINAL (RD_TIMEOUT)
   ) u_timer (
      .CLK   (CLK),
      .RST   (RST),
      .i_clr (w_tmr_clr),
      .i_en  (w_tmr_en),
      .o_tc  (w_tmr_tc)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_tx_data   <= '0;
         r_rf_wren   <= 1'b0;
         r_rf_rden   <= 1'b0;
         r_rf_addr   <= '0;
         r_rf_wrdata <= '0;
         r_tx_p_data <= '0;
         r_tx_d_vld  <= 1'b0;
         r_cmd_err   <= 1'b0;
      end else begin
         // NOTE: strobes default low every cycle and are raised only by the case below, keeping each pulse one cycle wide.
         r_rf_wren  <= 1'b0;
         r_rf_rden  <= 1'b0;
         r_tx_d_vld <= 1'b0;
         r_cmd_err  <= 1'b0;
         if (w_abort) begin
            r_cmd_err <= 1'b1;
            r_state   <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (bus.RX_D_VLD) begin
                     if (bus.RX_P_DATA == CMD_WR)      r_state   <= ST_WR_ADDR;
                     else if (bus.RX_P_DATA == CMD_RD) r_state   <= ST_RD_ADDR;
                     else                              r_cmd_err <= 1'b1;
                  end
               end
               ST_WR_ADDR: begin
                  if (bus.RX_D_VLD) begin
                     r_addr  <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                     r_state <= ST_WR_DATA;
                  end
               end
               ST_WR_DATA: begin
                  if (bus.RX_D_VLD) begin
                     r_rf_wren   <= 1'b1;
                     r_rf_addr   <= r_addr;
                     r_rf_wrdata <= bus.RX_P_DATA;
                     r_state     <= ST_IDLE;
                  end
               end
               ST_RD_ADDR: begin
                  if (bus.RX_D_VLD) begin
                     r_addr    <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                     r_rf_rden <= 1'b1;
                     r_rf_addr <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                     r_state   <= ST_RD_WAIT;
                  end
               end
               ST_RD_WAIT: begin
                  if (bus.RF_RdData_VLD) begin
                     r_tx_data <= bus.RF_RdData;
                     r_state   <= ST_TX_SEND;
                  end else if (w_tmr_tc) begin
                     r_cmd_err <= 1'b1;
                     r_state   <= ST_IDLE;
                  end
               end
               ST_TX_SEND: begin
                  if (!bus.TX_BUSY) begin
                     r_tx_d_vld  <= 1'b1;
                     r_tx_p_data <= r_tx_data;
                     r_state     <= ST_IDLE;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.RF_WrEn    = r_rf_wren;
   assign bus.RF_RdEn    = r_rf_rden;
   assign bus.RF_Address = r_rf_addr;
   assign bus.RF_WrData  = r_rf_wrdata;
   assign bus.TX_P_DATA  = r_tx_p_data;
   assign bus.TX_D_VLD   = r_tx_d_vld;
   assign bus.CMD_ERR    = r_cmd_err;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus pushes expected strobes (kind,
// cycle, address, data) into a queue; a negedge monitor pops and compares.
module tb_uart_cmd_ctrl;
   import uart_cmd_pkg::*;

   localparam int DW  = 8;
   localparam int AW  = 4;
   localparam int TMO = RD_TIMEOUT_DEF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   uart_cmd_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .CMD_WR     (8'hAA),
      .CMD_RD     (8'hBB),
      .RD_TIMEOUT (TMO)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   typedef enum int {K_WR = 0, K_RD = 1, K_TX = 2, K_ERR = 3} kind_e;
   typedef struct {
      kind_e kind;
      int    addr;
      int    data;
      int    cyc;
   } exp_t;

   exp_t          sb[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [AW-1:0] hold_addr   = '0;
   logic [DW-1:0] hold_wrdata = '0;
   logic [DW-1:0] hold_tx     = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic push(input kind_e k, input int a, input int d, input int c);
      exp_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      e.cyc  = c;
      sb.push_back(e);
   endtask

   task automatic pop_cmp(input kind_e k, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_strobe: got kind %0d, expected none (cycle %0d)", k, cyc);
      end else begin
         e = sb.pop_front();
         check("strobe_kind", k, e.kind);
         check("strobe_cycle", cyc, e.cyc);
         case (k)
            K_WR: begin
               check("wr_addr", a, e.addr);
               check("wr_data", d, e.data);
               hold_addr   = AW'(e.addr);
               hold_wrdata = DW'(e.data);
            end
            K_RD: begin
               check("rd_addr", a, e.addr);
               hold_addr = AW'(e.addr);
            end
            K_TX: begin
               check("tx_data", d, e.data);
               hold_tx = DW'(e.data);
            end
            default: ;
         endcase
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.RF_WrEn)  pop_cmp(K_WR, bus.RF_Address, bus.RF_WrData);
         if (bus.RF_RdEn)  pop_cmp(K_RD, bus.RF_Address, '0);
         if (bus.TX_D_VLD) pop_cmp(K_TX, '0, bus.TX_P_DATA);
         if (bus.CMD_ERR)  pop_cmp(K_ERR, '0, '0);
         if (!bus.RF_WrEn && !bus.RF_RdEn) check("rf_addr_hold", bus.RF_Address, hold_addr);
         if (!bus.RF_WrEn)  check("rf_wrdata_hold", bus.RF_WrData, hold_wrdata);
         if (!bus.TX_D_VLD) check("tx_data_hold", bus.TX_P_DATA, hold_tx);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit perr, input bit serr, output int e);
      bus.RX_P_DATA  = b;
      bus.RX_D_VLD   = 1'b1;
      bus.RX_PAR_ERR = perr;
      bus.RX_STP_ERR = serr;
      tick();
      e = cyc;
      bus.RX_D_VLD   = 1'b0;
      bus.RX_PAR_ERR = 1'b0;
      bus.RX_STP_ERR = 1'b0;
      bus.RX_P_DATA  = DW'($urandom);
   endtask

   task automatic check_outputs_zero();
      check("rst_wren", bus.RF_WrEn, 0);
      check("rst_rden", bus.RF_RdEn, 0);
      check("rst_addr", bus.RF_Address, 0);
      check("rst_wrdata", bus.RF_WrData, 0);
      check("rst_tx_data", bus.TX_P_DATA, 0);
      check("rst_tx_vld", bus.TX_D_VLD, 0);
      check("rst_cmd_err", bus.CMD_ERR, 0);
   endtask

   // Write frame: the register address is the address byte modulo 2**AW.
   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      int e;
      send_byte(8'hAA, 1'b0, 1'b0, e);
      gap();
      send_byte(a, 1'b0, 1'b0, e);
      gap();
      send_byte(d, 1'b0, 1'b0, e);
      push(K_WR, int'(a) % (1 << AW), int'(d), e);
      tick();
   endtask

   task automatic do_bad(input logic [7:0] b);
      int e;
      send_byte(b, 1'b0, 1'b0, e);
      push(K_ERR, 0, 0, e);
      tick();
   endtask

   // Read frame: read data arrives lat cycles after the address byte; the
   // response is accepted only if lat <= TMO, else an error appears at +TMO.
   task automatic do_read(input logic [7:0] a, input logic [7:0] d, input int lat,
                          input int busy_cyc, input bit junk_en, input logic [7:0] junk_b);
      int e;
      int v;
      bus.TX_BUSY = (busy_cyc > 0);
      send_byte(8'hBB, 1'b0, 1'b0, e);
      gap();
      send_byte(a, 1'b0, 1'b0, e);
      push(K_RD, int'(a) % (1 << AW), 0, e);
      if (lat > TMO) push(K_ERR, 0, 0, e + TMO);
      for (int k = 1; k < lat && k <= TMO + 3; k++) begin
         if (junk_en && k <= TMO && (k == 1 || $urandom_range(0, 1) == 1)) begin
            bus.RX_P_DATA = junk_b;
            bus.RX_D_VLD  = 1'b1;
         end
         tick();
         bus.RX_D_VLD = 1'b0;
      end
      if (lat <= TMO + 3) begin
         bus.RF_RdData     = d;
         bus.RF_RdData_VLD = 1'b1;
         tick();
         v = cyc;
         bus.RF_RdData_VLD = 1'b0;
         bus.RF_RdData     = DW'($urandom);
         if (lat <= TMO) begin
            if (busy_cyc > 0) begin
               repeat (busy_cyc) tick();
               bus.TX_BUSY = 1'b0;
               push(K_TX, 0, int'(d), cyc + 1);
            end else begin
               push(K_TX, 0, int'(d), v + 1);
            end
         end
      end
      bus.TX_BUSY = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      int e;
      logic [7:0] b;

      bus.RX_P_DATA     = '0;
      bus.RX_D_VLD      = 1'b0;
      bus.RX_PAR_ERR    = 1'b0;
      bus.RX_STP_ERR    = 1'b0;
      bus.RF_RdData     = '0;
      bus.RF_RdData_VLD = 1'b0;
      bus.TX_BUSY       = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero();
      rst = 1'b0;
      tick();

      do_write(8'h03, 8'h5C);
      do_read(8'h07, 8'hA5, 2, 0, 1'b0, 8'h00);
      do_read(8'h07, 8'hA5, 2, 20, 1'b0, 8'h00);
      do_bad(8'h12);
      do_read(8'h01, 8'h00, 99, 0, 1'b0, 8'h00);
      do_read(8'h04, 8'h3C, TMO, 0, 1'b0, 8'h00);
      do_read(8'h05, 8'hC3, TMO + 1, 0, 1'b0, 8'h00);
      do_write(8'hF9, 8'h11);
      do_read(8'h0A, 8'h5A, 4, 0, 1'b1, 8'h55);

`ifdef UART_CMD_ERR_ABORT_EN
      send_byte(8'hAA, 1'b0, 1'b0, e);
      send_byte(8'h02, 1'b1, 1'b0, e);
      push(K_ERR, 0, 0, e);
      tick();
      send_byte(8'hBB, 1'b0, 1'b1, e);
      push(K_ERR, 0, 0, e);
      tick();
`else
      send_byte(8'hAA, 1'b0, 1'b0, e);
      send_byte(8'h02, 1'b1, 1'b0, e);
      send_byte(8'h77, 1'b0, 1'b1, e);
      push(K_WR, 2, 8'h77, e);
      tick();
`endif

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: do_write(DW'($urandom), DW'($urandom));
            4, 5, 6, 7: do_read(DW'($urandom), DW'($urandom), $urandom_range(1, TMO + 2),
                                ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : 0,
                                1'($urandom_range(0, 1)), DW'($urandom));
            default: begin
               do b = DW'($urandom); while (b == 8'hAA || b == 8'hBB);
               do_bad(b);
            end
         endcase
         gap();
      end

      do_write(8'h0E, 8'hE7);
      do_read(8'h03, 8'h96, 1, 0, 1'b0, 8'h00);
      send_byte(8'hAA, 1'b0, 1'b0, e);
      send_byte(8'h02, 1'b0, 1'b0, e);
      rst = 1'b1;
      #2;
      check_outputs_zero();
      hold_addr   = '0;
      hold_wrdata = '0;
      hold_tx     = '0;
      tick();
      rst = 1'b0;
      tick();
      do_bad(8'h44);

      for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
      check("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
